// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths, base address and FSM encoding for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

  localparam int REGISTER_FILE_LEN = 32;
  localparam int SRAM_ADDR_LEN     = 18;
  localparam int SRAM_DATA_LEN     = 16;
  localparam int WORD_IDX_LEN      = SRAM_ADDR_LEN - 1;

  localparam logic [REGISTER_FILE_LEN-1:0] DATA_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Each 32-bit word occupies two consecutive SRAM half-word locations.
  function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(input logic [WORD_IDX_LEN-1:0] word_idx,
                                                         input logic upper);
    return {word_idx, upper};
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Loadable 4-bit down-counter timing one SRAM half-access; last is high while the count is 0.
// Load has priority over counting; the count saturates at 0.
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 4'd0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage load/store to a 16-bit SRAM as two half-word accesses of HALF_CYCLES each.
// ready drops the cycle a request appears and rises in DONE, 2*HALF_CYCLES+1 cycles later.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int HALF_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_r_en,
  input  logic                         mem_w_en,
  input  logic [REGISTER_FILE_LEN-1:0] alu_res,
  input  logic [31:0]                  val_r_m,
  output logic                         ready,
  output logic [31:0]                  mem_rdata,
  output logic [SRAM_ADDR_LEN-1:0]     sram_addr,
  output logic [SRAM_DATA_LEN-1:0]     sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0]     sram_dq_in,
  output logic                         sram_dq_oe,
  output logic                         sram_we_n
);

  localparam logic [3:0] RELOAD = 4'(HALF_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [WORD_IDX_LEN-1:0]    off_q, off_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       is_write_q, is_write_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [SRAM_ADDR_LEN-1:0]   addr_q, addr_d;
  logic [SRAM_DATA_LEN-1:0]   dq_q, dq_d;
  logic                       we_n_q, we_n_d;
  logic                       oe_q, oe_d;

  logic                          req;
  logic                          cnt_load;
  logic                          cnt_last;
  logic [REGISTER_FILE_LEN-1:0]  off_full;
  logic                          unused_off_bits;

  assign req      = mem_r_en | mem_w_en;
  assign off_full = alu_res - DATA_MEM_BASE;
  // Byte-in-word bits and everything above 512 KiB are dropped, so accesses alias.
  assign unused_off_bits = ^{off_full[REGISTER_FILE_LEN-1:19], off_full[1:0]};

  sram_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .last     (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    cnt_load   = 1'b0;

    case (state_q)
      ST_IDLE: if (req) begin
        off_d      = off_full[18:2];
        wdata_d    = val_r_m;
        is_write_d = mem_w_en;
        cnt_load   = 1'b1;
        state_d    = ST_LOW;
      end
      ST_LOW: if (cnt_last) begin
        if (!is_write_q) rdata_d[15:0] = sram_dq_in;
        cnt_load = 1'b1;
        state_d  = ST_HIGH;
      end
      ST_HIGH: if (cnt_last) begin
        if (!is_write_q) rdata_d[31:16] = sram_dq_in;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with LOW/HIGH.
    addr_d = addr_q;
    dq_d   = dq_q;
    we_n_d = 1'b1;
    oe_d   = 1'b0;
    case (state_d)
      ST_LOW: begin
        addr_d = half_addr(off_d, 1'b0);
        dq_d   = wdata_d[15:0];
        we_n_d = ~is_write_d;
        oe_d   = is_write_d;
      end
      ST_HIGH: begin
        addr_d = half_addr(off_d, 1'b1);
        dq_d   = wdata_d[31:16];
        we_n_d = ~is_write_d;
        oe_d   = is_write_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      dq_q       <= '0;
      we_n_q     <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      we_n_q     <= we_n_d;
      oe_q       <= oe_d;
    end
  end

  assign ready       = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign mem_rdata   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_oe  = oe_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: an H=3 instance on a behavioural SRAM plus an H=1 instance
// on a fixed-pattern SRAM, checked against a word-level reference memory.
module tb_mem_stage_sram_ctrl;

  localparam int H  = 3;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en, w_en, r_en1, w_en1;
  logic [31:0] alu, vrm, alu1, vrm1;

  logic        ready3, ready1;
  logic [31:0] rdata3, rdata1;
  logic [17:0] addr3, addr1;
  logic [15:0] dqo3, dqo1;
  logic [15:0] dqi3 = 16'h0;
  logic [15:0] dqi1 = 16'h0;
  logic        oe3, oe1, wen3, wen1;

  mem_stage_sram_ctrl #(.HALF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .mem_r_en(r_en), .mem_w_en(w_en), .alu_res(alu), .val_r_m(vrm),
    .ready(ready3), .mem_rdata(rdata3), .sram_addr(addr3), .sram_dq_out(dqo3),
    .sram_dq_in(dqi3), .sram_dq_oe(oe3), .sram_we_n(wen3)
  );

  mem_stage_sram_ctrl #(.HALF_CYCLES(H1)) dut_h1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1), .alu_res(alu1), .val_r_m(vrm1),
    .ready(ready1), .mem_rdata(rdata1), .sram_addr(addr1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(wen1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_load;

  // Default SRAM contents for never-written locations.
  function automatic logic [15:0] pat(input logic [17:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'h9E3779B1;
    return t[31:16] ^ 16'h1357;
  endfunction

  // Behavioural SRAM: a half-word commits only after H consecutive strobe cycles on one address.
  logic [15:0] sram    [0:262143];
  bit          sram_wr [0:262143];
  int          run3 = 0;
  logic [17:0] prev3 = '0;
  logic        pre_vld;
  logic [17:0] pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin : sram_model
    int nrun;
    nrun = (run3 > 0 && addr3 == prev3) ? run3 + 1 : 1;
    if (!wen3) begin
      run3  <= nrun;
      prev3 <= addr3;
      if (nrun == H) begin
        sram[addr3]    <= dqo3;
        sram_wr[addr3] <= 1'b1;
      end
    end else begin
      run3 <= 0;
    end
    if (pre_vld) begin
      sram[pre_a]    <= pre_d;
      sram_wr[pre_a] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    dqi3 <= sram_wr[addr3] ? sram[addr3] : pat(addr3);
    dqi1 <= pat(addr1);
  end

  function automatic logic [15:0] env_rd(input int a);
    return sram_wr[a] ? sram[a] : pat(18'(a));
  endfunction

  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(18'(a));
  endfunction

  function automatic int lo_half(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off % 32'h80000) / 32'd4) * 2;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    pre_a   = 18'(a);
    pre_d   = d;
    pre_vld = 1'b1;
    next_cycle();
    pre_vld = 1'b0;
    ref_mem[a] = d;
  endtask

  // One full access on the H=3 instance; cycle 0 is the first cycle the request is driven.
  task automatic run_access(input logic re, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input int en_cycles, input bit hold,
                            input bit noise, input string name);
    int          lo;
    bit          is_w;
    logic [31:0] exp_rd;
    logic        exp_ready;
    logic [35:0] exp_bus;
    logic [35:0] got_bus;
    lo     = lo_half(a);
    is_w   = we;
    exp_rd = {ref_rd(lo + 1), ref_rd(lo)};
    for (int c = 0; c <= 2 * H + 1; c++) begin
      if (c < en_cycles) begin
        r_en = re; w_en = we; alu = a; vrm = d;
      end else if (!hold) begin
        r_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        w_en = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        alu  = $urandom;
        vrm  = $urandom;
      end
      @(negedge clk);
      exp_ready = (c == 2 * H + 1);
      checks++;
      if (ready3 !== exp_ready) begin
        errors++;
        $display("FAIL %s ready c=%0d got %0b exp %0b", name, c, ready3, exp_ready);
      end
      got_bus = {addr3, dqo3, wen3, oe3};
      if (c >= 1 && c <= 2 * H) begin
        if (c <= H) exp_bus = {18'(lo), d[15:0], ~is_w, is_w};
        else        exp_bus = {18'(lo + 1), d[31:16], ~is_w, is_w};
        checks++;
        if (got_bus !== exp_bus) begin
          errors++;
          $display("FAIL %s bus c=%0d got %h exp %h", name, c, got_bus, exp_bus);
        end
      end else begin
        checks++;
        if ({wen3, oe3} !== 2'b10) begin
          errors++;
          $display("FAIL %s strobe_idle c=%0d got %b exp 10", name, c, {wen3, oe3});
        end
      end
      if (c == 0) begin
        checks++;
        if (rdata3 !== last_load) begin
          errors++;
          $display("FAIL %s rdata_held got %h exp %h", name, rdata3, last_load);
        end
      end
      if (c == 2 * H + 1) begin
        checks++;
        if (rdata3 !== (is_w ? last_load : exp_rd)) begin
          errors++;
          $display("FAIL %s rdata_done got %h exp %h", name, rdata3, is_w ? last_load : exp_rd);
        end
      end
      next_cycle();
    end
    if (is_w) begin
      ref_mem[lo]     = d[15:0];
      ref_mem[lo + 1] = d[31:16];
      checks++;
      if ({env_rd(lo + 1), env_rd(lo)} !== d) begin
        errors++;
        $display("FAIL %s sram_word got %h exp %h", name, {env_rd(lo + 1), env_rd(lo)}, d);
      end
    end else begin
      last_load = exp_rd;
    end
    if (!hold) begin
      r_en = 1'b0;
      w_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({ready3, addr3, dqo3, wen3, oe3, rdata3} !== {1'b1, 18'd0, 16'd0, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got %h", {ready3, addr3, dqo3, wen3, oe3, rdata3});
    end
    checks++;
    if ({ready1, wen1, oe1, rdata1} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state_h1 got %h", {ready1, wen1, oe1, rdata1});
    end
    r_en = 1'b1;
    #1;
    checks++;
    if (ready3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_req got %0b exp 0", ready3);
    end
    r_en = 1'b0;
    rst  = 1'b0;
    next_cycle();
  endtask

  task automatic test_load();
    preload(4, 16'h5678);
    preload(5, 16'h1234);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1, 1'b0, 1'b0, "load");
    checks++;
    if (rdata3 !== 32'h12345678) begin
      errors++;
      $display("FAIL load_value got %h exp 12345678", rdata3);
    end
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1, 1'b0, 1'b1, "store");
    checks++;
    if ({env_rd(1), env_rd(0), rdata3} !== {16'hDEAD, 16'hBEEF, 32'h12345678}) begin
      errors++;
      $display("FAIL store_result got %h exp deadbeef12345678", {env_rd(1), env_rd(0), rdata3});
    end
  endtask

  task automatic test_both_enables();
    run_access(1'b1, 1'b1, 32'd1024 + 32'd40, $urandom, 1, 1'b0, 1'b1, "both_en");
  endtask

  task automatic test_enable_drop();
    run_access(1'b1, 1'b0, 32'd1024 + 32'd40, 32'h0, 2, 1'b0, 1'b0, "en_drop");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1, 1'b1, 1'b0, "b2b_first");
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 1023));
      endcase
      case ($urandom_range(0, 2))
        0:       run_access(1'b1, 1'b0, a, $urandom, $urandom_range(1, 3), 1'b0, 1'b1, "rand_load");
        1:       run_access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 3), 1'b0, 1'b1, "rand_store");
        default: run_access(1'b1, 1'b1, a, $urandom, 1, 1'b0, 1'b1, "rand_both");
      endcase
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a, d;
    logic [15:0] old_hi;
    int          lo;
    a      = 32'd1024 + 32'd200;
    d      = $urandom;
    lo     = lo_half(a);
    old_hi = ref_rd(lo + 1);
    w_en = 1'b1; alu = a; vrm = d;
    next_cycle();
    w_en = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wen3, addr3} !== {1'b0, 18'(lo + 1)}) begin
      errors++;
      $display("FAIL midrst_strobe got %h exp %h", {wen3, addr3}, {1'b0, 18'(lo + 1)});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ready3, wen3, oe3, rdata3} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL midrst_state got %h exp %h", {ready3, wen3, oe3, rdata3}, {3'b110, 32'd0});
    end
    rst = 1'b0;
    next_cycle();
    ref_mem[lo] = d[15:0];
    last_load   = 32'd0;
    checks++;
    if ({env_rd(lo + 1), env_rd(lo)} !== {old_hi, d[15:0]}) begin
      errors++;
      $display("FAIL midrst_sram got %h exp %h", {env_rd(lo + 1), env_rd(lo)}, {old_hi, d[15:0]});
    end
  endtask

  task automatic test_half_cycles_1();
    logic [31:0] a, exp_rd;
    int          lo;
    a      = 32'd1024 + 32'd1000;
    lo     = lo_half(a);
    exp_rd = {pat(18'(lo + 1)), pat(18'(lo))};
    for (int c = 0; c <= 4; c++) begin
      r_en1 = (c == 0);
      alu1  = (c == 0) ? a : $urandom;
      @(negedge clk);
      checks++;
      if (ready1 !== (c >= 3)) begin
        errors++;
        $display("FAIL h1_ready c=%0d got %0b exp %0b", c, ready1, c >= 3);
      end
      if (c == 3) begin
        checks++;
        if (rdata1 !== exp_rd) begin
          errors++;
          $display("FAIL h1_rdata got %h exp %h", rdata1, exp_rd);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    r_en = 1'b0; w_en = 1'b0; alu = '0; vrm = '0;
    r_en1 = 1'b0; w_en1 = 1'b0; alu1 = '0; vrm1 = '0;
    pre_vld = 1'b0; pre_a = '0; pre_d = '0;
    last_load = 32'd0;
    test_reset();
    test_load();
    test_store();
    test_both_enables();
    test_enable_drop();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_half_cycles_1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
